apb_slave_regs: RTL and testbench
=================================

APB_SLAVE_REGS -- requirements
Module: apb_slave_regs

Interface
REQ-001 The block SHALL have parameter SLAVE_ID, default 0, meaning the index of the psel bit that selects this slave (legal 0..2).
REQ-002 The block SHALL have parameter WAIT_STATES, default 0, meaning the number of extra ACCESS cycles before pready (legal 0..15).
REQ-003 The block SHALL have parameter ID_VALUE, default 32'hA5B0_0001, meaning the constant returned by register 7.
REQ-004 The block SHALL have port hclk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port hresetn, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port psel, input, 3 bits: one-hot APB slave selects; only bit SLAVE_ID is used.
REQ-007 The block SHALL have port penable, input, 1 bit: the APB enable (ACCESS phase).
REQ-008 The block SHALL have port pwrite, input, 1 bit: 1 = write, 0 = read.
REQ-009 The block SHALL have port paddr, input, 32 bits: the byte address.
REQ-010 The block SHALL have port pwdata, input, 32 bits: the write data.
REQ-011 The block SHALL have port prdata, output, 32 bits: the read data.
REQ-012 The block SHALL have port pready, output, 1 bit: transfer completes in this cycle.
REQ-013 The block SHALL have port pslverr, output, 1 bit: error response, valid only while pready=1.

Function
REQ-014 The block SHALL contain 8 x 32-bit registers R0..R7 indexed by paddr[4:2]; R0..R6 SHALL be read/write; R7 SHALL read ID_VALUE and be read-only.
REQ-015 In sel (psel[SLAVE_ID]), the access SHALL be decoded as erroneous when paddr[1:0]!=0, when paddr[11:5]!=0, or on a write to R7; paddr[31:12] SHALL be ignored.
REQ-016 The FSM SHALL have the states IDLE, SETUP, WAIT, and RESP.
REQ-017 IDLE: sel&&!penable -> SETUP; sel&&penable (no setup) -> RESP with pslverr=1; otherwise stay in IDLE.
REQ-018 SETUP: the FSM SHALL latch paddr, pwrite, pwdata and the error decode, and load the wait counter (4 bits) with WAIT_STATES.
REQ-018a SETUP exit: the FSM SHALL go to RESP if WAIT_STATES=0, else to WAIT.
REQ-019 WAIT: the counter SHALL decrement each cycle while sel&&penable, going to RESP when the counter reaches 1.
REQ-020 RESP: pready=1 for exactly one cycle, then the FSM SHALL return to IDLE; if sel&&!penable in that cycle (back-to-back), it SHALL go to SETUP instead.
REQ-021 Resulting latency: pready SHALL be high in the (WAIT_STATES+1)-th cycle with penable=1.
REQ-021a Write effect: the write SHALL update the register on the RESP clock edge only, and only when no error is flagged.
REQ-022 Read data: prdata SHALL carry the addressed register value during the RESP cycle of a non-error read, and 32'h0 at all other times.
REQ-023 pslverr SHALL be 1 only in an error RESP cycle and 0 otherwise; an erroneous access SHALL change no register.
REQ-024 Abort: if sel drops in SETUP or WAIT, the FSM SHALL return to IDLE next cycle with no pready and no register update.
REQ-025 Input changes while in WAIT SHALL be ignored; the latched SETUP values SHALL be used.
REQ-026 psel bits other than SLAVE_ID SHALL have no effect; pready and pslverr SHALL stay 0 when the slave is not selected.

Reset
REQ-027 While hresetn=0, the block SHALL force the FSM to IDLE, the counter to 0, R0..R6 to 32'h0, and prdata, pready and pslverr to 0, asynchronously.
REQ-028 Reset mid-transfer SHALL discard the transfer with no register update; the block SHALL respond normally starting from the first SETUP after deassertion.

Verification
REQ-029 Bench check: with WAIT_STATES=0, write 32'hDEAD_BEEF to 0x04, then read 0x04 -> pready in the first ACCESS cycle of each transfer, prdata=32'hDEAD_BEEF, pslverr=0.
REQ-030 Bench check: with WAIT_STATES=3, read 0x1C -> pready low for 3 ACCESS cycles, high on the 4th, prdata=32'hA5B0_0001.
REQ-031 Bench check: write 32'h1234 to 0x1C, and separately to 0x22 -> each completes with pslverr=1; R7 still reads ID_VALUE; R0 is unchanged.
REQ-032 Bench check: write 0x0C, then drop psel in WAIT (WAIT_STATES=2) -> no pready; R3 still reads 32'h0.
REQ-033 Bench check: back-to-back writes to 0x00 and 0x08 (SETUP directly after RESP) -> both complete; R0 and R2 both hold the written values.
REQ-034 Bench check: assert hresetn=0 during the WAIT of a write to 0x10 -> outputs are 0 immediately; R4=32'h0; the next read of 0x10 returns 32'h0.

Source files
------------

// File: rtl/apb_slave_regs.sv
// APB slave with eight 32-bit registers: R0..R6 read/write, R7 a read-only ID constant.
// Latency: pready in the (WAIT_STATES+1)-th ACCESS cycle; prdata, pready and pslverr are decoded from registered state.
// Backpressure: wait states hold pready low; dropping psel before the response aborts with no register update.
//
// Ports:
//   hclk, hresetn            clock and asynchronous active-low reset
//   psel[2:0]                one-hot slave selects; only bit SLAVE_ID is used
//   penable, pwrite          APB ACCESS-phase flag and direction (1 = write)
//   paddr[31:0], pwdata      byte address (bits [31:12] ignored) and write data
//   prdata, pready, pslverr  read data, transfer done, error response
module apb_slave_regs #(
  parameter int          SLAVE_ID    = 0,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic [2:0]  psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [3:0] LP_WS = WAIT_STATES[3:0];

  state_t      r_state;
  state_t      w_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [2:0]  r_idx;
  logic        r_write;
  logic [31:0] r_wdata;
  logic        r_err;
  logic [31:0] r_regs [7];

  logic        w_sel;
  logic        w_err_dec;
  logic        w_latch;
  logic        w_dir_err;
  logic        w_cnt_dec;
  logic [31:0] w_rd_val;
  logic        w_unused;

  assign w_sel    = psel[SLAVE_ID];
  assign w_unused = ^{paddr[31:12], psel};

  assign w_err_dec = (paddr[1:0] != 2'b00) || (paddr[11:5] != 7'd0) ||
                     (pwrite && (paddr[4:2] == 3'd7));

  // SETUP is the APB setup-phase cycle itself: it is recognised combinationally
  // from IDLE (or from RESP for back-to-back) so that the setup values are
  // captured at the edge ending that cycle and a zero-wait transfer answers in
  // the first ACCESS cycle.
  always_comb begin
    w_state   = r_state;
    w_next    = S_IDLE;
    w_latch   = 1'b0;
    w_dir_err = 1'b0;
    w_cnt_dec = 1'b0;
    if (((r_state == S_IDLE) || (r_state == S_RESP)) && w_sel && !penable) begin
      w_state = S_SETUP;
    end
    case (w_state)
      S_IDLE: begin
        // ACCESS without a setup phase is answered with an error.
        if (w_sel && penable) begin
          w_next    = S_RESP;
          w_dir_err = 1'b1;
        end
      end
      S_SETUP: begin
        w_latch = 1'b1;
        w_next  = (LP_WS == 4'd0) ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (!w_sel) begin
          w_next = S_IDLE;
        end else if (penable) begin
          w_cnt_dec = 1'b1;
          w_next    = (r_cnt <= 4'd1) ? S_RESP : S_WAIT;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_cnt   <= 4'd0;
      r_idx   <= 3'd0;
      r_write <= 1'b0;
      r_wdata <= 32'h0;
      r_err   <= 1'b0;
    end else if (w_latch) begin
      r_cnt   <= LP_WS;
      r_idx   <= paddr[4:2];
      r_write <= pwrite;
      r_wdata <= pwdata;
      r_err   <= w_err_dec;
    end else if (w_dir_err) begin
      r_write <= pwrite;
      r_err   <= 1'b1;
    end else if (w_cnt_dec) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Writes commit at the edge closing the response cycle, so an abort or a
  // reset before the response leaves the register file untouched.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      for (int i = 0; i < 7; i++) begin
        r_regs[i] <= 32'h0;
      end
    end else if ((r_state == S_RESP) && r_write && !r_err) begin
      for (int i = 0; i < 7; i++) begin
        if (r_idx == 3'(i)) begin
          r_regs[i] <= r_wdata;
        end
      end
    end
  end

  always_comb begin
    w_rd_val = ID_VALUE;
    for (int i = 0; i < 7; i++) begin
      if (r_idx == 3'(i)) begin
        w_rd_val = r_regs[i];
      end
    end
  end

  assign pready  = (r_state == S_RESP);
  assign pslverr = pready && r_err;
  assign prdata  = (pready && !r_err && !r_write) ? w_rd_val : 32'h0;

endmodule

// File: tb/tb_apb_slave_regs.sv
// Bench for apb_slave_regs: three slaves on one APB bus (SLAVE_ID 0/1/2 with 0/3/2 wait states).
// Expected responses are queued when a transfer is driven and compared when pready appears.
module tb_apb_slave_regs;

  logic             hclk = 1'b0;
  logic             hresetn;
  logic [2:0]       psel;
  logic             penable;
  logic             pwrite;
  logic [31:0]      paddr;
  logic [31:0]      pwdata;
  logic [2:0][31:0] prdata_v;
  logic [2:0]       pready_v;
  logic [2:0]       pslverr_v;

  localparam logic [31:0] ID = 32'hA5B0_0001;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  always #5 hclk = ~hclk;

  apb_slave_regs #(.SLAVE_ID(0), .WAIT_STATES(0)) u_s0 (
    .hclk(hclk), .hresetn(hresetn), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[0]), .pready(pready_v[0]), .pslverr(pslverr_v[0]));
  apb_slave_regs #(.SLAVE_ID(1), .WAIT_STATES(3)) u_s1 (
    .hclk(hclk), .hresetn(hresetn), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[1]), .pready(pready_v[1]), .pslverr(pslverr_v[1]));
  apb_slave_regs #(.SLAVE_ID(2), .WAIT_STATES(2)) u_s2 (
    .hclk(hclk), .hresetn(hresetn), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[2]), .pready(pready_v[2]), .pslverr(pslverr_v[2]));

  function automatic int ws_of(input int s);
    case (s)
      0:       return 0;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  // One APB transfer to slave s; leaves the bus selected when last=0 so the
  // next call's setup phase follows the response directly.
  task automatic apb_xfer(input int s, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rd,
                          input logic exp_err, input bit last);
    exp_t e;
    int   n;
    bit   done;
    e.rdata = (wr || exp_err) ? 32'h0 : exp_rd;
    e.err   = exp_err;
    e.lat   = ws_of(s) + 1;
    sb_q.push_back(e);
    @(posedge hclk); #1;
    psel    = 3'b000;
    psel[s] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wdata;
    @(posedge hclk); #1;
    penable = 1'b1;
    n    = 1;
    done = 1'b0;
    while (!done && n <= 20) begin
      @(negedge hclk);
      if (pready_v[s] === 1'b1) begin
        done = 1'b1;
      end else begin
        @(posedge hclk); #1;
        n++;
      end
    end
    e = sb_q.pop_front();
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL timeout slave%0d addr=%h: no pready within 20 access cycles", s, addr);
    end else begin
      if (n !== e.lat) begin
        errors++;
        $display("FAIL latency slave%0d addr=%h: got %0d access cycles, want %0d", s, addr, n, e.lat);
      end
      checks++;
      if (prdata_v[s] !== e.rdata) begin
        errors++;
        $display("FAIL prdata slave%0d addr=%h: got %h, want %h", s, addr, prdata_v[s], e.rdata);
      end
      checks++;
      if (pslverr_v[s] !== e.err) begin
        errors++;
        $display("FAIL pslverr slave%0d addr=%h: got %b, want %b", s, addr, pslverr_v[s], e.err);
      end
      checks++;
      if ((pready_v & ~(3'b001 << s)) !== 3'b000) begin
        errors++;
        $display("FAIL unselected_pready slave%0d: pready vector %b", s, pready_v);
      end
    end
    if (last) begin
      @(posedge hclk); #1;
      psel    = 3'b000;
      penable = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (pready_v !== 3'b000 || pslverr_v !== 3'b000 || prdata_v !== '0) begin
      errors++;
      $display("FAIL %s: pready=%b pslverr=%b prdata=%h, want all zero", name, pready_v, pslverr_v, prdata_v);
    end
  endtask

  task automatic test_reset();
    hresetn = 1'b0;
    psel    = 3'b000;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 32'h0;
    pwdata  = 32'h0;
    repeat (2) @(posedge hclk);
    #1;
    check_all_zero("reset_outputs");
    hresetn = 1'b1;
    apb_xfer(0, 1'b0, 32'h0000_0000, 32'h0, 32'h0, 1'b0, 1'b1);
    apb_xfer(2, 1'b0, 32'h0000_0018, 32'h0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic test_rw_ws0();
    apb_xfer(0, 1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1);
    apb_xfer(0, 1'b0, 32'h0000_0004, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
    // Upper address bits are ignored.
    apb_xfer(0, 1'b0, 32'hFFFF_F004, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
    // Slave 1 has its own register file.
    apb_xfer(1, 1'b0, 32'h0000_0004, 32'h0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic test_id_ws3();
    apb_xfer(1, 1'b0, 32'h0000_001C, 32'h0, ID, 1'b0, 1'b1);
    apb_xfer(1, 1'b1, 32'h0000_0018, 32'h0BAD_F00D, 32'h0, 1'b0, 1'b1);
    apb_xfer(1, 1'b0, 32'h0000_0018, 32'h0, 32'h0BAD_F00D, 1'b0, 1'b1);
  endtask

  task automatic test_errors();
    apb_xfer(0, 1'b1, 32'h0000_001C, 32'h0000_1234, 32'h0, 1'b1, 1'b1);
    apb_xfer(0, 1'b1, 32'h0000_0022, 32'h0000_1234, 32'h0, 1'b1, 1'b1);
    apb_xfer(0, 1'b0, 32'h0000_001C, 32'h0, ID, 1'b0, 1'b1);
    apb_xfer(0, 1'b0, 32'h0000_0000, 32'h0, 32'h0, 1'b0, 1'b1);
    apb_xfer(0, 1'b1, 32'h0000_0020, 32'h0000_5678, 32'h0, 1'b1, 1'b1);
    apb_xfer(0, 1'b0, 32'h0000_0000, 32'h0, 32'h0, 1'b0, 1'b1);
    // An erroneous read returns zero data.
    apb_xfer(0, 1'b0, 32'h0000_0005, 32'h0, 32'h0, 1'b1, 1'b1);
    // ACCESS without a setup phase.
    @(posedge hclk); #1;
    psel    = 3'b001;
    penable = 1'b1;
    pwrite  = 1'b1;
    paddr   = 32'h0000_0000;
    pwdata  = 32'hFFFF_FFFF;
    @(posedge hclk); #1;
    psel    = 3'b000;
    penable = 1'b0;
    @(negedge hclk);
    checks++;
    if (pready_v[0] !== 1'b1 || pslverr_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL no_setup_err: pready=%b pslverr=%b, want 1 1", pready_v[0], pslverr_v[0]);
    end
    apb_xfer(0, 1'b0, 32'h0000_0000, 32'h0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic test_abort();
    @(posedge hclk); #1;
    psel    = 3'b100;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h0000_000C;
    pwdata  = 32'h5555_AAAA;
    @(posedge hclk); #1;
    penable = 1'b1;
    @(negedge hclk);
    checks++;
    if (pready_v !== 3'b000) begin
      errors++;
      $display("FAIL abort_wait1: pready=%b, want 000", pready_v);
    end
    @(posedge hclk); #1;
    psel    = 3'b000;
    penable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge hclk);
      checks++;
      if (pready_v !== 3'b000) begin
        errors++;
        $display("FAIL abort_no_pready cycle %0d: pready=%b, want 000", i, pready_v);
      end
    end
    apb_xfer(2, 1'b0, 32'h0000_000C, 32'h0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    apb_xfer(0, 1'b1, 32'h0000_0000, 32'h1111_0000, 32'h0, 1'b0, 1'b0);
    apb_xfer(0, 1'b1, 32'h0000_0008, 32'h2222_0008, 32'h0, 1'b0, 1'b0);
    apb_xfer(0, 1'b0, 32'h0000_0000, 32'h0, 32'h1111_0000, 1'b0, 1'b0);
    apb_xfer(0, 1'b0, 32'h0000_0008, 32'h0, 32'h2222_0008, 1'b0, 1'b1);
    apb_xfer(2, 1'b1, 32'h0000_0014, 32'h3333_0014, 32'h0, 1'b0, 1'b0);
    apb_xfer(2, 1'b0, 32'h0000_0014, 32'h0, 32'h3333_0014, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    // Reset during the WAIT of a write.
    @(posedge hclk); #1;
    psel    = 3'b100;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h0000_0010;
    pwdata  = 32'h7777_0010;
    @(posedge hclk); #1;
    penable = 1'b1;
    @(posedge hclk); #1;
    hresetn = 1'b0;
    #1;
    check_all_zero("reset_in_wait");
    psel    = 3'b000;
    penable = 1'b0;
    @(posedge hclk); #1;
    hresetn = 1'b1;
    apb_xfer(2, 1'b0, 32'h0000_0010, 32'h0, 32'h0, 1'b0, 1'b1);
    // Reset during a response cycle clears the outputs at once.
    @(posedge hclk); #1;
    psel    = 3'b001;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 32'h0000_001C;
    @(posedge hclk); #1;
    penable = 1'b1;
    @(negedge hclk);
    checks++;
    if (pready_v[0] !== 1'b1 || prdata_v[0] !== ID) begin
      errors++;
      $display("FAIL resp_before_reset: pready=%b prdata=%h, want 1 %h", pready_v[0], prdata_v[0], ID);
    end
    #1;
    hresetn = 1'b0;
    #1;
    check_all_zero("reset_in_resp");
    @(posedge hclk); #1;
    psel    = 3'b000;
    penable = 1'b0;
    hresetn = 1'b1;
    apb_xfer(0, 1'b0, 32'h0000_0004, 32'h0, 32'h0, 1'b0, 1'b1);
    apb_xfer(0, 1'b0, 32'h0000_0008, 32'h0, 32'h0, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_rw_ws0();
    test_id_ws3();
    test_errors();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
